// File: rtl/ctrl_banco_alu.sv
// Multi-cycle sequencer: accepts one register-register instruction, reads the bank,
// drives the ALU, and writes the result back (IDLE -> READ -> EXEC -> WRITE).
module ctrl_banco_alu #(
  parameter int              DW     = 8,
  parameter int              AW     = 3,
  parameter int              OPW    = 3,
  parameter logic [OPW-1:0]  OP_CMP = 3'b111
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [OPW-1:0] instr_op,
  input  logic [AW-1:0]  instr_rd,
  input  logic [AW-1:0]  instr_rs1,
  input  logic [AW-1:0]  instr_rs2,
  output logic [AW-1:0]  rd_addr1,
  output logic [AW-1:0]  rd_addr2,
  input  logic [DW-1:0]  rd_data1,
  input  logic [DW-1:0]  rd_data2,
  output logic           wr_en,
  output logic [AW-1:0]  wr_addr,
  output logic [DW-1:0]  wr_data,
  output logic [OPW-1:0] alu_op,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  input  logic [DW-1:0]  alu_y,
  input  logic           alu_zero,
  output logic           zero_flag,
  output logic           done
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t         state, next_state;
  logic           handshake;
  logic [OPW-1:0] op_q;
  logic [OPW-1:0] op_exec_q;
  logic [AW-1:0]  rd_q, rs1_q, rs2_q;
  logic [DW-1:0]  a_q, b_q, res_q;

  assign handshake = instr_valid & instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (handshake) next_state = READ;
      READ:  next_state = EXEC;
      EXEC:  next_state = WRITE;
      WRITE: next_state = handshake ? READ : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    wr_en       = 1'b0;
    done        = 1'b0;
    unique case (state)
      IDLE:  instr_ready = 1'b1;
      WRITE: begin
        instr_ready = 1'b1;
        done        = 1'b1;
        wr_en       = (op_q != OP_CMP);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      op_exec_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      zero_flag <= 1'b0;
    end else begin
      if (handshake) begin
        op_q  <= instr_op;
        rd_q  <= instr_rd;
        rs1_q <= instr_rs1;
        rs2_q <= instr_rs2;
      end
      // ALU opcode gets its own copy so alu_op holds the previous value during the next READ
      if (state == READ) begin
        a_q       <= rd_data1;
        b_q       <= rd_data2;
        op_exec_q <= op_q;
      end
      if (state == EXEC) begin
        res_q     <= alu_y;
        zero_flag <= alu_zero;
      end
    end
  end

  assign rd_addr1 = rs1_q;
  assign rd_addr2 = rs2_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_exec_q;
  assign wr_addr  = rd_q;
  assign wr_data  = res_q;

endmodule

// File: tb/tb_ctrl_banco_alu.sv
// Bench for ctrl_banco_alu: bank/ALU environment, ISA-level reference model checked
// every cycle, directed cases with literal expectations, then randomized traffic.
module tb_ctrl_banco_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid, instr_ready;
  logic [2:0] instr_op, instr_rd, instr_rs1, instr_rs2;
  logic [2:0] rd_addr1, rd_addr2, wr_addr, alu_op;
  logic [7:0] rd_data1, rd_data2, wr_data, alu_a, alu_b, alu_y;
  logic       wr_en, alu_zero, zero_flag, done;

  logic [7:0] bank [8];
  logic       pre_en;
  logic [2:0] pre_addr;
  logic [7:0] pre_data;
  logic [8:0] alu_res;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  ctrl_banco_alu #(.DW(8), .AW(3), .OPW(3), .OP_CMP(3'b111)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_zero(alu_zero),
    .zero_flag(zero_flag), .done(done)
  );

  // ALU used by both the environment and the model: returns {zero, y}
  function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] y;
    case (op)
      3'd0: y = a + b;
      3'd1: y = a - b;
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = a << 1;
      3'd6: y = a >> 1;
      default: y = a - b;
    endcase
    return {(y == 8'd0), y};
  endfunction

  assign rd_data1 = bank[rd_addr1];
  assign rd_data2 = bank[rd_addr2];
  assign alu_res  = alu_f(alu_op, alu_a, alu_b);
  assign alu_y    = alu_res[7:0];
  assign alu_zero = alu_res[8];

  always @(posedge clk) begin
    if (pre_en)     bank[pre_addr] <= pre_data;
    else if (wr_en) bank[wr_addr]  <= wr_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
  endtask

  // Issue one instruction from idle; returns after the accept edge with valid dropped
  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
    int unsigned waited = 0;
    @(posedge clk); #1;
    drive(op, rd, rs1, rs2);
    @(negedge clk);
    while (!instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!instr_ready) check("issue_timeout", 0, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  // Reference model state: architectural registers plus at most one in-flight instruction
  logic [7:0] arch [8];
  int         cyc = 0;
  logic       pend = 1'b0;
  int         wc = 0;
  logic [2:0] p_op, p_rd, p_rs1, p_rs2;
  logic [7:0] p_a, p_b, p_y;
  logic       p_z;
  logic       m_zf = 1'b0;

  task automatic monitor();
    logic       retiring;
    logic [8:0] r;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pend = 1'b0;
        m_zf = 1'b0;
      end else begin
        if (pre_en) arch[pre_addr] = pre_data;
        retiring = pend && (cyc == wc);
        if (retiring) m_zf = p_z;
        check("m_ready", instr_ready, !pend || retiring);
        check("m_done", done, retiring);
        check("m_wr_en", wr_en, retiring && (p_op != 3'd7));
        check("m_zero_flag", zero_flag, m_zf);
        if (retiring) begin
          check("m_wr_addr", wr_addr, p_rd);
          check("m_wr_data", wr_data, p_y);
          if (p_op != 3'd7) arch[p_rd] = p_y;
          pend = 1'b0;
        end
        if (pend && cyc == wc - 2) begin
          check("m_rd_addr1", rd_addr1, p_rs1);
          check("m_rd_addr2", rd_addr2, p_rs2);
        end
        if (pend && cyc == wc - 1) begin
          check("m_alu_a", alu_a, p_a);
          check("m_alu_b", alu_b, p_b);
          check("m_alu_op", alu_op, p_op);
        end
        if (instr_valid && !pend) begin
          p_op = instr_op; p_rd = instr_rd; p_rs1 = instr_rs1; p_rs2 = instr_rs2;
          p_a = arch[instr_rs1];
          p_b = arch[instr_rs2];
          r = alu_f(p_op, p_a, p_b);
          p_y = r[7:0];
          p_z = r[8];
          wc = cyc + 3;
          pend = 1'b1;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) arch[i] = 8'd0;
    rst_n = 1'b0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", instr_ready, 1);
    check("rst_wr_en", wr_en, 0);
    check("rst_done", done, 0);
    check("rst_zero_flag", zero_flag, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_wr_data", wr_data, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Single ADD R1 = R2 + R3
    preload(3'd2, 8'd5);
    preload(3'd3, 8'd7);
    issue(3'd0, 3'd1, 3'd2, 3'd3);
    @(negedge clk);
    check("add_rd_addr1", rd_addr1, 2);
    check("add_rd_addr2", rd_addr2, 3);
    check("add_ready_read", instr_ready, 0);
    @(negedge clk);
    check("add_alu_a", alu_a, 5);
    check("add_alu_b", alu_b, 7);
    check("add_ready_exec", instr_ready, 0);
    @(negedge clk);
    check("add_wr_en", wr_en, 1);
    check("add_wr_addr", wr_addr, 1);
    check("add_wr_data", wr_data, 12);
    check("add_done", done, 1);
    @(negedge clk);
    check("add_r1", bank[1], 12);

    // Back-to-back ADD then dependent SUB R4 = R1 - R2, fields switched while busy
    @(posedge clk); #1;
    drive(3'd0, 3'd1, 3'd2, 3'd3);
    @(posedge clk); #1;
    drive(3'd1, 3'd4, 3'd1, 3'd2);
    @(negedge clk);
    check("b2b_rd_addr1_first", rd_addr1, 2);
    @(negedge clk);
    check("b2b_alu_a_first", alu_a, 5);
    @(negedge clk);
    check("b2b_done_first", done, 1);
    check("b2b_wr_data_first", wr_data, 12);
    check("b2b_ready_write", instr_ready, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    check("b2b_rd_addr1", rd_addr1, 1);
    check("b2b_done_gap", done, 0);
    @(negedge clk);
    check("b2b_alu_a", alu_a, 12);
    check("b2b_alu_b", alu_b, 5);
    check("b2b_alu_op", alu_op, 1);
    @(negedge clk);
    check("b2b_wr_addr", wr_addr, 4);
    check("b2b_wr_data", wr_data, 7);
    check("b2b_done_second", done, 1);

    // CMP: flags only
    preload(3'd5, 8'h3C);
    preload(3'd6, 8'h3C);
    preload(3'd7, 8'h99);
    issue(3'd7, 3'd7, 3'd5, 3'd6);
    repeat (3) @(negedge clk);
    check("cmp_wr_en", wr_en, 0);
    check("cmp_done", done, 1);
    check("cmp_zero_flag", zero_flag, 1);
    @(negedge clk);
    check("cmp_r7", bank[7], 8'h99);
    check("cmp_zero_held", zero_flag, 1);

    // Self-overwrite with 8-bit wrap
    preload(3'd0, 8'hFF);
    issue(3'd0, 3'd0, 3'd0, 3'd0);
    repeat (3) @(negedge clk);
    check("self_wr_data", wr_data, 8'hFE);
    check("self_zero_flag", zero_flag, 0);
    check("self_wr_en", wr_en, 1);
    @(negedge clk);
    check("self_r0", bank[0], 8'hFE);

    // Reset during EXEC
    preload(3'd1, 8'h11);
    issue(3'd0, 3'd1, 3'd2, 3'd3);
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rexec_wr_en", wr_en, 0);
    check("rexec_done", done, 0);
    check("rexec_ready", instr_ready, 1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rexec_r1", bank[1], 8'h11);

    // Reset during WRITE: enable must drop at once
    issue(3'd0, 3'd1, 3'd2, 3'd3);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    check("rwr_wr_en_before", wr_en, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rwr_wr_en_after", wr_en, 0);
    check("rwr_done_after", done, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rwr_r1", bank[1], 8'h11);

    // Randomized traffic with fields changing every cycle
    for (int i = 0; i < 8; i++) preload(3'(i), 8'($urandom));
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      instr_valid = ($urandom % 4) != 0;
      instr_op  = 3'($urandom);
      instr_rd  = 3'($urandom);
      instr_rs1 = 3'($urandom);
      instr_rs2 = 3'($urandom);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 8; i++) check("final_bank", bank[i], arch[i]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/ctrl_banco_alu.md
Name: ctrl_banco_alu

Overview:
- Multi-cycle sequencer between an instruction source, the 8x8 register bank and the ALU.
- Accepts one register-register instruction per valid/ready handshake and reads both source operands from the bank.
- Drives the ALU, captures the result and zero flag, and writes the result back to the bank.
- Sole owner of the bank's write enable and address ports in the processor top level.

Parameters:
- DW, 8, data width of bank and ALU
- AW, 3, register address width (2^AW registers)
- OPW, 3, ALU opcode width
- OP_CMP, 3'b111, opcode that updates flags only, no writeback

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- instr_valid  input  1  instruction available
- instr_ready  output  1  controller can accept instruction
- instr_op  input  OPW  ALU operation
- instr_rd  input  AW  destination register
- instr_rs1  input  AW  source register 1
- instr_rs2  input  AW  source register 2
- rd_addr1  output  AW  to bank read port 1
- rd_addr2  output  AW  to bank read port 2
- rd_data1  input  DW  from bank read port 1 (combinational)
- rd_data2  input  DW  from bank read port 2 (combinational)
- wr_en  output  1  bank write enable
- wr_addr  output  AW  bank write address
- wr_data  output  DW  bank write data
- alu_op  output  OPW  ALU opcode
- alu_a  output  DW  ALU operand A
- alu_b  output  DW  ALU operand B
- alu_y  input  DW  ALU result (combinational from alu_a/alu_b/alu_op)
- alu_zero  input  1  ALU zero flag (combinational)
- zero_flag  output  1  registered zero flag of last executed instruction
- done  output  1  one-cycle pulse per retired instruction

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- State machine states: IDLE, READ, EXEC, WRITE. Reset state: IDLE.
- Reset values: all instruction and operand registers, result register, wr_en, done and zero_flag are 0.
- Reset mid-operation: abandons the instruction; wr_en drops immediately (asynchronous), so no partial write.
- instr_ready = 1 in IDLE and WRITE, 0 in READ and EXEC. Handshake fires on instr_valid & instr_ready at a rising edge.
- Accept: latches op, rd, rs1, rs2; next state READ.
- IDLE without valid: stays in IDLE.
- READ:
  - rd_addr1 = latched rs1, rd_addr2 = latched rs2.
  - At the end of the cycle, rd_data1/rd_data2 are captured into operand registers A/B. Next state EXEC.
- EXEC:
  - alu_a = A, alu_b = B, alu_op = latched op (registered values).
  - At the end of the cycle, alu_y is captured into the result register and alu_zero into zero_flag. Next state WRITE.
- WRITE:
  - wr_addr = latched rd, wr_data = result.
  - wr_en = 1 unless op == OP_CMP, in which case wr_en = 0.
  - done = 1 for this cycle.
  - Next state READ if a handshake fires this cycle, else IDLE.
- Outside WRITE: wr_en = 0 and done = 0. rd_addr* and alu_* hold their last values outside READ and EXEC.
- Latency: accept edge to write edge is 3 cycles. Back-to-back throughput is 1 instruction per 3 cycles.
- Hazard-free by construction: the next instruction's READ follows the WRITE edge, so a rs1/rs2 equal to the previous rd reads the new value without forwarding.
- rd == rs1 == rs2 is legal: the sources are read before the write.
- Width rules:
  - alu_y is truncated to DW by the ALU.
  - The controller does no arithmetic, but keeps the result unmodified.
  - zero_flag is stale-held across CMP and non-CMP alike until the next EXEC.
- instr_* fields are ignored whenever no handshake fires. Changing them while instr_ready = 0 has no effect.

Test Plan:
- Reset mid-EXEC: assert rst_n = 0 during EXEC of a write to R1 -> wr_en = 0 immediately, state IDLE, R1 unchanged, done never pulses.
- Single ADD: R2 = 5, R3 = 7 preloaded, instr ADD rd = 1 rs1 = 2 rs2 = 3 -> rd_addr1/2 = 2/3 in READ, alu_a/b = 5/7 in EXEC, wr_en = 1 with wr_addr = 1, wr_data = 12, done = 1 exactly 3 cycles after accept. R1 reads 12 afterwards.
- Back-to-back dependency: ADD R1 = R2 + R3 (12), then SUB R4 = R1 - R2 offered continuously -> second accepted in first's WRITE cycle, reads R1 = 12, writes R4 = 7, done pulses 3 cycles apart.
- CMP: R5 = R6 = 0x3C, op = OP_CMP rd = 7 -> wr_en stays 0, R7 unchanged, zero_flag = 1, done = 1.
- Backpressure: instr_valid held high with fields toggling during READ/EXEC -> only values present on accept/WRITE-edge handshakes are executed. instr_ready low in READ/EXEC.
- Self-overwrite: R0 = 0xFF, ADD rd = rs1 = rs2 = 0 with 8-bit wrap -> wr_data = 0xFE, zero_flag = 0.
